// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the game sequencer: phase codes, hand ranks, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_sequencer_pkg;

  // Phase codes reported to the settlement block on game_s
  localparam logic [1:0] GS_IDLE      = 2'b00;
  localparam logic [1:0] GS_SETTLE    = 2'b01;
  localparam logic [1:0] GS_CHOICE    = 2'b10;
  localparam logic [1:0] GS_HL_SETTLE = 2'b11;

  // Hand rank codes from the evaluator; 0010..1000 and 1010 pay out
  localparam logic [3:0] RANK_NONE     = 4'b0000;
  localparam logic [3:0] RANK_LOW_PAIR = 4'b0001;
  localparam logic [3:0] RANK_WIN_MIN  = 4'b0010;
  localparam logic [3:0] RANK_WIN_MAX  = 4'b1000;
  localparam logic [3:0] RANK_BONUS    = 4'b1010;

  // Bankroll assumed before the first accepted bet
  localparam logic [15:0] DEFAULT_BANKROLL = 16'd1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL,
    ST_WAIT_EVAL,
    ST_SETTLE,
    ST_CHOICE,
    ST_HL_WAIT,
    ST_HL_SETTLE
  } state_t;

  function automatic logic is_winning_rank(input logic [3:0] rank);
    return ((rank >= RANK_WIN_MIN) && (rank <= RANK_WIN_MAX)) || (rank == RANK_BONUS);
  endfunction

endpackage

// File: rtl/game_sequencer_choice_timer.sv
// Cycle counter bounding how long the player may sit in the double-up choice.
// Latency: expire_o is combinational on the current count; count updates each clock.
// Backpressure: none; clear has priority over enable.
module choice_timer #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic clock,
  input  logic reset_c,
  input  logic clear_c,
  input  logic enable_c,
  output logic expire_o
);

  logic [15:0] count_q;

  // Count cycles while enabled, restart from zero whenever cleared
  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      count_q <= '0;
    end else if (clear_c) begin
      count_q <= '0;
    end else if (enable_c) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expire_o = enable_c && (count_q == (TIMEOUT - 16'd1));

endmodule

// File: rtl/game_sequencer.sv
// Game flow FSM: bet check, deal, poker settle, optional double-up (GRABLU_DOUBLE_UP_EN).
// Latency: all outputs except game_over_o are registered, one cycle after the causing input.
// Backpressure: none; waits indefinitely for eval_done_i / hl_valid_i, ignores unlisted pulses.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter logic [15:0] MIN_BET        = 16'd10,
  parameter logic [15:0] MAX_BET        = 16'd500,
  parameter logic [15:0] CHOICE_TIMEOUT = 16'd1000
) (
  input  logic        clock,
  input  logic        reset_c,
  input  logic        bet_c,
  input  logic [15:0] wager_i,
  input  logic [15:0] money_i,
  input  logic        eval_done_i,
  input  logic [3:0]  hand_r,
  input  logic        du_c,
  input  logic        collect_c,
  input  logic        hl_valid_i,
  output logic [1:0]  game_s,
  output logic [15:0] wager_o,
  output logic [15:0] mih_o,
  output logic        deal_req_o,
  output logic        hl_req_o,
  output logic        bet_err_o,
  output logic        game_over_o
);

  state_t      state;
  logic [3:0]  hand_q;
  logic        hl_req_q;
  logic        broke;
  logic        bet_ok;
  logic        choice_expire;

  // A broke player can never place a legal bet, so the range checks alone would reject,
  // but the explicit term keeps game_over_o and the rejection visibly tied together.
  assign broke  = (money_i < MIN_BET);
  assign bet_ok = !broke && (wager_i >= MIN_BET) && (wager_i <= MAX_BET) && (wager_i <= money_i);

  assign game_over_o = (state == ST_IDLE) && broke;

`ifdef GRABLU_DOUBLE_UP_EN
  choice_timer #(
    .TIMEOUT (CHOICE_TIMEOUT)
  ) u_choice_timer (
    .clock    (clock),
    .reset_c  (reset_c),
    .clear_c  (state != ST_CHOICE),
    .enable_c (state == ST_CHOICE),
    .expire_o (choice_expire)
  );
  assign hl_req_o = hl_req_q;
`else
  assign choice_expire = 1'b0;
  assign hl_req_o      = 1'b0;
  logic unused_double_up;
  assign unused_double_up = ^{du_c, collect_c, hl_valid_i, hand_q, hl_req_q, choice_expire, CHOICE_TIMEOUT};
`endif

  // Main game FSM; game_s and the request/error pulses are registered alongside the state
  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      state      <= ST_IDLE;
      game_s     <= GS_IDLE;
      wager_o    <= '0;
      mih_o      <= DEFAULT_BANKROLL;
      deal_req_o <= 1'b0;
      hl_req_q   <= 1'b0;
      bet_err_o  <= 1'b0;
      hand_q     <= RANK_NONE;
    end else begin
      deal_req_o <= 1'b0;
      hl_req_q   <= 1'b0;
      bet_err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bet_c) begin
            if (bet_ok) begin
              wager_o    <= wager_i;
              mih_o      <= money_i;
              deal_req_o <= 1'b1;
              state      <= ST_DEAL;
            end else begin
              bet_err_o <= 1'b1;
            end
          end
        end
        ST_DEAL: begin
          state <= ST_WAIT_EVAL;
        end
        ST_WAIT_EVAL: begin
          if (eval_done_i) begin
            hand_q <= hand_r;
            game_s <= GS_SETTLE;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
`ifdef GRABLU_DOUBLE_UP_EN
          if (is_winning_rank(hand_q)) begin
            game_s <= GS_CHOICE;
            state  <= ST_CHOICE;
          end else begin
            game_s <= GS_IDLE;
            state  <= ST_IDLE;
          end
`else
          game_s <= GS_IDLE;
          state  <= ST_IDLE;
`endif
        end
`ifdef GRABLU_DOUBLE_UP_EN
        ST_CHOICE: begin
          // Collect outranks a simultaneous double-up request
          if (collect_c || choice_expire) begin
            game_s <= GS_IDLE;
            state  <= ST_IDLE;
          end else if (du_c) begin
            game_s   <= GS_IDLE;
            hl_req_q <= 1'b1;
            state    <= ST_HL_WAIT;
          end
        end
        ST_HL_WAIT: begin
          if (hl_valid_i) begin
            game_s <= GS_HL_SETTLE;
            state  <= ST_HL_SETTLE;
          end
        end
        ST_HL_SETTLE: begin
          game_s <= GS_IDLE;
          state  <= ST_IDLE;
        end
`endif
        default: begin
          game_s <= GS_IDLE;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter MIN_BET, default 16'd10, the minimum legal wager.
REQ-002 SHALL have parameter MAX_BET, default 16'd500, the maximum legal wager.
REQ-003 SHALL have parameter CHOICE_TIMEOUT, default 16'd1000, the number of cycles allowed in CHOICE before auto-collect.
REQ-004 SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_c, input, 1, the reset: asynchronous and active-low.
REQ-006 SHALL have port bet_c, input, 1, a one-cycle bet/start pulse.
REQ-007 SHALL have port wager_i, input, 16, the player-selected wager.
REQ-008 SHALL have port money_i, input, 16, the current bankroll (money_r from the settlement block).
REQ-009 SHALL have port eval_done_i, input, 1, a pulse meaning hand_r is valid.
REQ-010 SHALL have port hand_r, input, 4, the hand rank code.
REQ-011 SHALL have ports du_c and collect_c, input, 1 each, the player's double-up and collect pulses.
REQ-012 SHALL have port hl_valid_i, input, 1, a pulse meaning the high/low compare result is ready.
REQ-013 SHALL have port game_s, output, 2, the phase to the settlement block: 00 idle/play, 01 poker settle, 10 choice, 11 high/low settle.
REQ-014 SHALL have ports wager_o and mih_o, output, 16 each, the latched wager and the money held at bet time.
REQ-015 SHALL have port deal_req_o, output, 1, a one-cycle request to the dealer/evaluator.
REQ-016 SHALL have port hl_req_o, output, 1, a one-cycle request to the high/low compare.
REQ-017 SHALL have ports bet_err_o (1-cycle pulse) and game_over_o (level), output, 1 each.

Function
REQ-018 SHALL implement the states IDLE, DEAL, WAIT_EVAL, SETTLE, CHOICE, HL_WAIT and HL_SETTLE.
REQ-019 In IDLE, a bet_c with MIN_BET<=wager_i<=MAX_BET and wager_i<=money_i SHALL latch wager_o<=wager_i and mih_o<=money_i, then go to DEAL.
REQ-020 An illegal bet_c SHALL pulse bet_err_o for 1 cycle and stay in IDLE, with wager_o and mih_o unchanged.
REQ-021 DEAL SHALL assert deal_req_o for exactly 1 cycle, then go to WAIT_EVAL.
REQ-022 WAIT_EVAL SHALL wait indefinitely for eval_done_i, then register hand_r and go to SETTLE.
REQ-023 SETTLE SHALL drive game_s=01 for exactly 1 cycle.
REQ-024 From SETTLE, a winning rank (0010-1000 or 1010) SHALL go to CHOICE; any other rank SHALL go to IDLE.
REQ-025 CHOICE SHALL drive game_s=10 and run a cycle counter.
REQ-026 In CHOICE, du_c SHALL go to HL_WAIT with hl_req_o asserted for 1 cycle.
REQ-027 In CHOICE, collect_c, or the counter reaching CHOICE_TIMEOUT-1, SHALL go to IDLE.
REQ-028 If du_c and collect_c arrive in the same cycle, collect_c SHALL win.
REQ-029 HL_WAIT SHALL wait for hl_valid_i, then go to HL_SETTLE.
REQ-030 HL_SETTLE SHALL drive game_s=11 for exactly 1 cycle, then go to IDLE.
REQ-031 game_s SHALL be 00 in IDLE, DEAL, WAIT_EVAL and HL_WAIT, and SHALL be a registered output.
REQ-032 wager_o and mih_o SHALL be held constant from latch until the next accepted bet.
REQ-033 game_over_o SHALL be high in IDLE whenever money_i < MIN_BET, and bet_c SHALL then be rejected with bet_err_o.
REQ-034 bet_c, du_c and collect_c SHALL be ignored in states where they are not listed above.
REQ-035 The wager comparisons SHALL be 16-bit unsigned with no overflow.

Reset
REQ-036 Reset SHALL force state=IDLE, game_s=00, wager_o=0, mih_o=16'd1000, deal_req_o=0, hl_req_o=0, bet_err_o=0 and counter=0, immediately, from any state.
REQ-037 After reset, game_over_o SHALL follow REQ-033.

Configuration
REQ-038 With macro GRABLU_DOUBLE_UP_EN defined, CHOICE, HL_WAIT and HL_SETTLE SHALL exist as specified above.
REQ-039 Without GRABLU_DOUBLE_UP_EN, SETTLE SHALL always go to IDLE, hl_req_o SHALL be tied to 0, game_s SHALL never be 10 or 11, and du_c, collect_c and hl_valid_i SHALL be unused.

Structure
REQ-040 A shared package SHALL hold the game_s codes, the hand_r rank codes, the FSM state typedef and the default bankroll 16'd1000.
REQ-041 One sub-module, choice_timer, SHALL implement the CHOICE_TIMEOUT counter (clear, enable, expire).

Verification
REQ-042 Reset, then bet_c with wager_i=100 and money_i=1000 -> wager_o=100, mih_o=1000, and deal_req_o pulses 1 cycle later.
REQ-043 wager_i=5, or wager_i=600, or wager_i=1200 with money_i=1000 -> bet_err_o pulses, and the state stays IDLE.
REQ-044 eval_done_i with hand_r=0001 -> game_s=01 for 1 cycle, then 00, with no CHOICE.
REQ-045 hand_r=0100, then du_c, then hl_valid_i -> game_s sequence 01, 10..., 00, 11 (1 cycle), 00, and hl_req_o pulses once.
REQ-046 hand_r=0101, no input for CHOICE_TIMEOUT cycles -> returns to IDLE; du_c and collect_c in the same cycle -> IDLE.
REQ-047 reset_c low during WAIT_EVAL -> all outputs take their reset values asynchronously; money_i=5 -> game_over_o=1.
